alu_req_responder: RTL and testbench
====================================

// Module: alu_req_responder
// PURPOSE
//  Registered request/response front-end for the 16-bit ALU: the responder end of the op_code/input1/input2/cin/bin stimulus interface.
//  Accepts one ALU command per valid/ready handshake, executes it, holds the result until the consumer accepts it.
//  Sits between the CPU issue stage (or bench driver) and the writeback path.
// PARAMETERS
//  WIDTH      16     operand/result width
//  OP_W       4      op_code width
// PORTS
//  clk         in   1      system clock, rising edge
//  rst_n       in   1      asynchronous reset, active-low
//  req_valid   in   1      command valid
//  req_ready   out  1      responder can accept command
//  req_op      in   OP_W   op_code
//  req_a       in   WIDTH  operand 1
//  req_b       in   WIDTH  operand 2
//  req_cin     in   1      carry-in (ADD)
//  req_bin     in   1      borrow-in (SUB)
//  rsp_valid   out  1      response valid
//  rsp_ready   in   1      consumer accepts response
//  rsp_result  out  WIDTH  result
//  rsp_carry   out  1      ADD carry-out / SUB borrow-out, else 0
//  rsp_zero    out  1      rsp_result == 0
//  rsp_err     out  1      illegal op_code; rsp_result = 0
// BEHAVIOUR
//  Ops: 0 ADD a+b+cin; 1 SUB a-b-bin; 2 AND; 3 OR; 4 XOR; 5 NOT a; 6 MUL (macro only); others illegal.
//  Arithmetic at WIDTH+1 bits; bit WIDTH is carry/borrow; result truncated to WIDTH.
//  FSM: IDLE -> (handshake, op!=MUL) RESP; IDLE -> (handshake, MUL) EXEC; EXEC -> (count done) RESP;
//       RESP -> (rsp_ready) IDLE, or RESP again if a new non-MUL command handshakes that cycle.
//  req_ready = (state==IDLE) | (state==RESP & rsp_ready); combinational from rsp_ready.
//  Operands captured at handshake; req_* ignored otherwise.
//  Latency: handshake at edge N -> rsp_valid high after edge N+1 (single-cycle ops).
//  rsp_* stable while rsp_valid & !rsp_ready; rsp_valid never drops without handshake.
//  Back-to-back: response accepted and new command accepted same cycle -> no bubble.
//  Only one command outstanding; no buffering beyond the response register.
//  Reset (any state, incl. mid-EXEC): state=IDLE, rsp_valid=0, rsp_result=0, rsp_carry=0,
//    rsp_zero=0, rsp_err=0, multiplier counter=0; in-flight command discarded.
//  req_ready is 0 during reset assertion.
// CONFIGURATION
//  ALU_MUL_EN defined: op 6 = unsigned shift-add multiply, WIDTH cycles in EXEC,
//    rsp_result = low WIDTH bits of product, rsp_carry = |high WIDTH bits;
//    rsp_valid after edge N+1+WIDTH; req_ready=0 during EXEC.
//  ALU_MUL_EN undefined: op 6 illegal (rsp_err=1, single-cycle); EXEC state and counter absent.
// STRUCTURE
//  alu_pkg: op_code enum (OP_ADD..OP_MUL), state enum, WIDTH/OP_W defaults.
//  Sub-module alu_core: combinational single-cycle ops + err/carry; FSM/registers/multiplier in top.
// TESTING
//  1 Reset: rst_n=0 mid-traffic -> all rsp_* 0, req_ready 0; release -> req_ready 1 next cycle.
//  2 ADD a=16'hFFFF b=1 cin=0 -> result 0, carry 1, zero 1, rsp_valid one cycle after handshake.
//  3 SUB a=5 b=7 bin=1 -> result 16'hFFFD, carry(borrow) 1, zero 0; XOR a=b=16'hA5A5 -> 0, zero 1.
//  4 Backpressure: rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready 0; then rsp_ready=1 with
//    req_valid=1 (AND 16'hF0F0,16'h0FF0) -> next rsp 16'h00F0, no idle cycle.
//  5 Illegal op 4'hF (and op 6 without ALU_MUL_EN) -> rsp_err 1, result 0, carry 0.
//  6 ALU_MUL_EN: MUL 300*300 -> result 16'h5F90, carry 1, rsp_valid WIDTH+1 cycles after handshake;
//    rst_n pulse mid-EXEC -> no response emitted.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and sizing for the ALU request/response front-end.
// ALU_MUL_EN adds the OP_MUL opcode and the EXEC state used by the sequential multiplier.
package alu_pkg;

  localparam int WIDTH = 16;
  localparam int OP_W  = 4;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_AND = 4'd2,
    OP_OR  = 4'd3,
    OP_XOR = 4'd4,
    OP_NOT = 4'd5,
    OP_MUL = 4'd6
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
`ifdef ALU_MUL_EN
    ST_EXEC = 2'd2,
`endif
    ST_RESP = 2'd1
  } state_e;

endpackage

// File: rtl/alu_req_responder_if.sv
// Command/response bundle between an ALU command issuer (master) and the responder (slave).
interface alu_req_responder_if
  import alu_pkg::*;
#(
  parameter int IF_WIDTH = WIDTH,
  parameter int IF_OP_W  = OP_W
);

  logic                req_valid;
  logic                req_ready;
  logic [IF_OP_W-1:0]  req_op;
  logic [IF_WIDTH-1:0] req_a;
  logic [IF_WIDTH-1:0] req_b;
  logic                req_cin;
  logic                req_bin;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [IF_WIDTH-1:0] rsp_result;
  logic                rsp_carry;
  logic                rsp_zero;
  logic                rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, req_cin, req_bin, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_cin, req_bin, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
  );

endinterface

// File: rtl/alu_core.sv
// Combinational single-cycle ALU operations with carry/borrow and illegal-opcode flag.
// With ALU_MUL_EN, OP_MUL is legal here but produces no result; the top's multiplier handles it.
module alu_core
  import alu_pkg::*;
(
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             bin,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             err
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // Extra top bit of the WIDTH+1 arithmetic is the carry-out / borrow-out.
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
    diff   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    result = '0;
    carry  = 1'b0;
    err    = 1'b0;
    case (op_e'(op))
      OP_ADD: begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      OP_SUB: begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_NOT: result = ~a;
`ifdef ALU_MUL_EN
      OP_MUL: result = '0;
`endif
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_req_responder.sv
// Registered valid/ready responder for the 16-bit ALU: one command in flight, result held until taken.
// ALU_MUL_EN enables OP_MUL as a WIDTH-cycle shift-add multiply through the EXEC state.
module alu_req_responder
  import alu_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  alu_req_responder_if.slave bus
);

  state_e           state;
  state_e           state_next;
  state_e           accept_state;
  logic             req_ready;
  logic             hs;
  logic             is_mul;
  logic             load_single;
  logic [WIDTH-1:0] core_result;
  logic             core_carry;
  logic             core_err;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             zero_q;
  logic             err_q;

  alu_core u_core (
    .op     (bus.req_op),
    .a      (bus.req_a),
    .b      (bus.req_b),
    .cin    (bus.req_cin),
    .bin    (bus.req_bin),
    .result (core_result),
    .carry  (core_carry),
    .err    (core_err)
  );

  // Gated by rst_n so nothing is accepted while reset is held.
  assign req_ready = rst_n & ((state == ST_IDLE) | ((state == ST_RESP) & bus.rsp_ready));
  assign hs        = bus.req_valid & req_ready;

`ifdef ALU_MUL_EN
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               mul_done;

  assign is_mul       = (op_e'(bus.req_op) == OP_MUL);
  assign accept_state = is_mul ? ST_EXEC : ST_RESP;
  assign acc_next     = acc + (mplier[0] ? mcand : '0);
  assign mul_done     = (state == ST_EXEC) && (cnt == CNT_W'(WIDTH - 1));

  // One partial product per EXEC cycle; the last one is folded straight into the response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (hs && is_mul) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, bus.req_a};
      mplier <= bus.req_b;
      cnt    <= '0;
    end else if (state == ST_EXEC) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
    end
  end
`else
  assign is_mul       = 1'b0;
  assign accept_state = ST_RESP;
`endif

  assign load_single = hs & ~is_mul;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (hs) begin
          state_next = accept_state;
        end
      end
      ST_RESP: begin
        if (hs) begin
          state_next = accept_state;
        end else if (bus.rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
`ifdef ALU_MUL_EN
      ST_EXEC: begin
        if (mul_done) begin
          state_next = ST_RESP;
        end
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Response registers only load on acceptance, so they hold steady under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (load_single) begin
      result_q <= core_result;
      carry_q  <= core_carry;
      zero_q   <= (core_result == '0);
      err_q    <= core_err;
`ifdef ALU_MUL_EN
    end else if (mul_done) begin
      result_q <= acc_next[WIDTH-1:0];
      carry_q  <= |acc_next[2*WIDTH-1:WIDTH];
      zero_q   <= (acc_next[WIDTH-1:0] == '0);
      err_q    <= 1'b0;
`endif
    end
  end

  assign bus.req_ready  = req_ready;
  assign bus.rsp_valid  = (state == ST_RESP);
  assign bus.rsp_result = result_q;
  assign bus.rsp_carry  = carry_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_err    = err_q;

endmodule

// File: tb/tb_alu_req_responder.sv
// Directed self-checking bench for alu_req_responder; the MUL checks run only when ALU_MUL_EN is defined.
module tb_alu_req_responder;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  alu_req_responder_if bus ();

  alu_req_responder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkResponse(input string tag, input logic [WIDTH-1:0] result, input logic carry,
                               input logic zero, input logic err);
    checkOutput({tag, "_valid"},  {31'd0, bus.rsp_valid}, 32'd1);
    checkOutput({tag, "_result"}, {16'd0, bus.rsp_result}, {16'd0, result});
    checkOutput({tag, "_carry"},  {31'd0, bus.rsp_carry}, {31'd0, carry});
    checkOutput({tag, "_zero"},   {31'd0, bus.rsp_zero}, {31'd0, zero});
    checkOutput({tag, "_err"},    {31'd0, bus.rsp_err}, {31'd0, err});
  endtask

  // Presents one command from a falling edge and returns #1 after the edge that accepts it.
  task automatic applyStimulus(input logic [OP_W-1:0] op, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic cin, input logic bin);
    bit done;
    done = 1'b0;
    @(negedge clk);
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_cin   = cin;
    bus.req_bin   = bin;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      #1;
      if (bus.req_ready) done = 1'b1;
      @(posedge clk);
      #1;
      if (!done) @(negedge clk);
    end
    bus.req_valid = 1'b0;
    if (!done) checkOutput("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic acceptResponse(input string tag);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput({tag, "_drained"}, {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    bus.req_valid = 1'b0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = 1'b0;
    bus.req_bin   = 1'b0;
    bus.rsp_ready = 1'b0;
    rst_n         = 1'b1;
    #2 rst_n = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    checkOutput("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("rst_result",    {16'd0, bus.rsp_result}, 32'd0);
    checkOutput("rst_flags",     {29'd0, bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("post_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("post_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);

    // Carry out of the top bit wraps the result to zero.
    applyStimulus(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    checkResponse("add_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);
    acceptResponse("add_wrap");

    applyStimulus(OP_SUB, 16'h0005, 16'h0007, 1'b0, 1'b1);
    checkResponse("sub_borrow", 16'hFFFD, 1'b1, 1'b0, 1'b0);
    acceptResponse("sub_borrow");

    applyStimulus(OP_ADD, 16'h1234, 16'h0101, 1'b1, 1'b0);
    checkResponse("add_cin", 16'h1336, 1'b0, 1'b0, 1'b0);
    acceptResponse("add_cin");

    applyStimulus(OP_NOT, 16'h00FF, 16'h1234, 1'b0, 1'b0);
    checkResponse("not", 16'hFF00, 1'b0, 1'b0, 1'b0);
    acceptResponse("not");

    applyStimulus(OP_OR, 16'h1200, 16'h0034, 1'b0, 1'b0);
    checkResponse("or", 16'h1234, 1'b0, 1'b0, 1'b0);
    acceptResponse("or");

    // XOR response is then held under backpressure while junk commands are offered.
    applyStimulus(OP_XOR, 16'hA5A5, 16'hA5A5, 1'b0, 1'b0);
    checkResponse("xor", 16'h0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_op    = OP_ADD;
      bus.req_a     = 16'h1111;
      bus.req_b     = 16'h2222;
      #1;
      checkOutput("bp_req_ready", {31'd0, bus.req_ready}, 32'd0);
      @(posedge clk);
      #1;
      checkResponse("bp_hold", 16'h0000, 1'b0, 1'b1, 1'b0);
    end

    @(negedge clk);
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = OP_AND;
    bus.req_a     = 16'hF0F0;
    bus.req_b     = 16'h0FF0;
    #1;
    checkOutput("b2b_req_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    checkResponse("b2b_and", 16'h00F0, 1'b0, 1'b0, 1'b0);
    acceptResponse("b2b_and");

    applyStimulus(4'hF, 16'h1234, 16'h5678, 1'b1, 1'b1);
    checkResponse("illegal_f", 16'h0000, 1'b0, 1'b1, 1'b1);
    acceptResponse("illegal_f");

`ifdef ALU_MUL_EN
    begin
      int cycles;
      int seen;
      applyStimulus(OP_MUL, 16'd300, 16'd300, 1'b0, 1'b0);
      checkOutput("mul_exec_req_ready", {31'd0, bus.req_ready}, 32'd0);
      cycles = 0;
      while (!bus.rsp_valid && cycles < 40) begin
        @(posedge clk);
        #1;
        cycles++;
      end
      checkOutput("mul_latency", cycles, WIDTH);
      checkResponse("mul_300x300", 16'h5F90, 1'b1, 1'b0, 1'b0);
      acceptResponse("mul_300x300");

      applyStimulus(OP_MUL, 16'd3, 16'd4, 1'b0, 1'b0);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkOutput("mul_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
      checkOutput("mul_rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 25; i++) begin
        @(posedge clk);
        #1;
        if (bus.rsp_valid) seen++;
      end
      checkOutput("mul_discarded", seen, 0);
    end
`else
    applyStimulus(OP_MUL, 16'd300, 16'd300, 1'b0, 1'b0);
    checkResponse("illegal_mul", 16'h0000, 1'b0, 1'b1, 1'b1);
    acceptResponse("illegal_mul");
`endif

    // Reset while a response is pending must drop it and clear every response field.
    applyStimulus(OP_ADD, 16'h0001, 16'h0002, 1'b1, 1'b0);
    checkResponse("pre_rst_add", 16'h0004, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    checkOutput("mid_rst_result",    {16'd0, bus.rsp_result}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_rst_release", {31'd0, bus.req_ready}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
